dm_bus_arbiter: RTL and testbench

- Two-master, single-port arbiter for the CPU data-memory bus (word addressed, 4-bit byte enables, combinational read, write on clock edge).
- Master 0 is the CPU data port. Master 1 is a secondary requester (DMA or debug loader).
- Each accepted request becomes one registered memory access, followed by a one-cycle acknowledge carrying the read data.
- Arbitration is round-robin. Out-of-range accesses are range-checked, blocked and flagged with an error.

---
 rtl/dm_bus_arbiter_if.sv | 43 ++++
 rtl/dm_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_bus_arbiter_if.sv
// Data-memory bus bundle: two requester ports plus the single memory port.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface dm_bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_byteen,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_addr, m1_wdata, m1_byteen,
    output m1_ack, m1_rdata, m1_err,
    output mem_en, mem_addr, mem_wdata, mem_byteen,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_byteen,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_addr, m1_wdata, m1_byteen,
    input  m1_ack, m1_rdata, m1_err,
    input  mem_en, mem_addr, mem_wdata, mem_byteen,
    output mem_rdata
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory bus: IDLE grants, BUSY drives
// one memory access, RESP returns a one-cycle ack with captured read data.
module dm_bus_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC
) (
  input  logic             clk,
  input  logic             reset,
  dm_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_byteen_q, req_byteen_d;
  logic        req_err_q, req_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  m_req;
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_byteen [2];
  logic [1:0]  m_ack;
  logic [1:0]  m_err;
  logic [31:0] m_rdata  [2];

  logic        grant_valid;
  logic        winner;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;

  assign m_req[0]    = bus.m0_req;
  assign m_addr[0]   = bus.m0_addr;
  assign m_wdata[0]  = bus.m0_wdata;
  assign m_byteen[0] = bus.m0_byteen;
  assign m_req[1]    = bus.m1_req;
  assign m_addr[1]   = bus.m1_addr;
  assign m_wdata[1]  = bus.m1_wdata;
  assign m_byteen[1] = bus.m1_byteen;

  // Requests are only looked at in IDLE; a still-high req during RESP is ignored.
  always_comb begin
    grant_valid = 1'b0;
    winner      = last_grant_q;
    if (state_q == IDLE) begin
      case (m_req)
        2'b01: begin
          grant_valid = 1'b1;
          winner      = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          winner      = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          winner      = ~last_grant_q;
        end
        default: begin
          grant_valid = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_byteen_d = req_byteen_q;
    req_err_d    = req_err_q;
    rdata_d      = rdata_q;
    mem_en       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_byteen   = '0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = winner;
          last_grant_d = winner;
          req_addr_d   = m_addr[winner];
          req_wdata_d  = m_wdata[winner];
          req_byteen_d = m_byteen[winner];
          req_err_d    = (m_addr[winner] >= ADDR_LIMIT);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Out-of-range accesses still present the address but never strobe memory.
        mem_en     = ~req_err_q;
        mem_addr   = req_addr_q & ADDR_MASK;
        mem_wdata  = req_wdata_q;
        mem_byteen = req_err_q ? 4'b0000 : req_byteen_q;
        rdata_d    = req_err_q ? 32'h0 : bus.mem_rdata;
        state_d    = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_byteen_q <= '0;
      req_err_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_byteen_q <= req_byteen_d;
      req_err_q    <= req_err_d;
      rdata_q      <= rdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign m_ack[gi]   = (state_q == RESP) && (owner_q == 1'(gi));
      assign m_rdata[gi] = m_ack[gi] ? rdata_q : 32'h0;
      assign m_err[gi]   = m_ack[gi] & req_err_q;
    end
  endgenerate

  assign bus.m0_ack   = m_ack[0];
  assign bus.m0_rdata = m_rdata[0];
  assign bus.m0_err   = m_err[0];
  assign bus.m1_ack   = m_ack[1];
  assign bus.m1_rdata = m_rdata[1];
  assign bus.m1_err   = m_err[1];

  assign bus.mem_en     = mem_en;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.mem_byteen = mem_byteen;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: vector table of single transactions plus
// hand-written contention, reset-in-BUSY and early-drop sequences.
module tb_dm_bus_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  dm_bus_arbiter_if bus ();

  dm_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data memory: combinational read, byte-enabled write, cleared by reset.
  logic [31:0] mem [4096];
  logic        pre_en;
  logic [11:0] pre_idx;
  logic [31:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else begin
      if (pre_en) mem[pre_idx] <= pre_data;
      if (bus.mem_en) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteen[b]) mem[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_en;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 1'b0) begin
      bus.m0_req = req; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_byteen = be;
    end else begin
      bus.m1_req = req; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_byteen = be;
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_m0_ack", {31'h0, bus.m0_ack}, 32'h0);
    chk("rst_m1_ack", {31'h0, bus.m1_ack}, 32'h0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("rst_m1_err", {31'h0, bus.m1_err}, 32'h0);
    chk("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_byteen", {28'h0, bus.mem_byteen}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic        own_ack, oth_ack, own_err;
    logic [31:0] own_rdata, oth_rdata;
    @(negedge clk);
    drive(v.m, 1'b1, v.addr, v.wdata, v.be);
    @(negedge clk);
    chk("busy_mem_en", {31'h0, bus.mem_en}, {31'h0, v.exp_en});
    chk("busy_mem_addr", bus.mem_addr, v.exp_maddr);
    chk("busy_mem_byteen", {28'h0, bus.mem_byteen}, {28'h0, v.exp_mbe});
    chk("busy_mem_wdata", bus.mem_wdata, v.wdata);
    chk("busy_no_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
    @(negedge clk);
    own_ack   = v.m ? bus.m1_ack   : bus.m0_ack;
    oth_ack   = v.m ? bus.m0_ack   : bus.m1_ack;
    own_err   = v.m ? bus.m1_err   : bus.m0_err;
    own_rdata = v.m ? bus.m1_rdata : bus.m0_rdata;
    oth_rdata = v.m ? bus.m0_rdata : bus.m1_rdata;
    chk("resp_ack", {31'h0, own_ack}, 32'h1);
    chk("resp_other_ack", {31'h0, oth_ack}, 32'h0);
    chk("resp_rdata", own_rdata, v.exp_rdata);
    chk("resp_err", {31'h0, own_err}, {31'h0, v.exp_err});
    chk("resp_other_rdata", oth_rdata, 32'h0);
    chk("resp_mem_en", {31'h0, bus.mem_en}, 32'h0);
    $display("txn %0d: m%0d addr=%h be=%b rdata=%h err=%b", idx, v.m, v.addr, v.be, own_rdata, own_err);
    drive(v.m, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp0, exp1;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0010, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0023, 32'hAB00_0000, 4'b1000, 1'b1, 32'h0000_0020, 4'b1000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0020, 4'b0000, 32'hAB00_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_4000, 32'h1234_5678, 4'b1111, 1'b0, 32'h0000_4000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0014, 32'h0000_5A5A, 4'b0011, 1'b1, 32'h0000_0014, 4'b0011, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0016, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0014, 4'b0000, 32'h0000_5A5A, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_3FFC, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_3FFC, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF0, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'hFFFF_FFF0, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0011_0000, 4'b0100, 1'b1, 32'h0000_0010, 4'b0100, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0011, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0010, 4'b0000, 32'hDE11_BEEF, 1'b0};

    reset_dut();
    preload(12'd4, 32'hDEAD_BEEF);
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Contention from reset: both hold req, grants must alternate m0,m1,m0,m1.
    reset_dut();
    preload(12'd4, 32'hDEAD_BEEF);
    preload(12'd8, 32'h0BAD_F00D);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h0000_0020, 32'h0, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
      exp1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
      chk("cont_m0_ack", {31'h0, bus.m0_ack}, {31'h0, exp0});
      chk("cont_m1_ack", {31'h0, bus.m1_ack}, {31'h0, exp1});
      if (exp0) chk("cont_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
      if (exp1) chk("cont_m1_rdata", bus.m1_rdata, 32'h0BAD_F00D);
      $display("cont cycle %0d: m0_ack=%b m1_ack=%b", k, bus.m0_ack, bus.m1_ack);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("cont_idle_mem_en", {31'h0, bus.mem_en}, 32'h0);

    // Reset during BUSY of an m1 read: ack dropped, then m0 wins the first tie.
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0024, 32'h0, 4'h0);
    @(negedge clk);
    chk("rmid_busy_en", {31'h0, bus.mem_en}, 32'h1);
    chk("rmid_busy_addr", bus.mem_addr, 32'h0000_0024);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_no_m1_ack", {31'h0, bus.m1_ack}, 32'h0);
    chk("rmid_mem_en", {31'h0, bus.mem_en}, 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'h0);
    @(negedge clk);
    chk("rmid_m0_first_addr", bus.mem_addr, 32'h0000_0030);
    @(negedge clk);
    chk("rmid_m0_ack", {31'h0, bus.m0_ack}, 32'h1);
    chk("rmid_m1_ack_low", {31'h0, bus.m1_ack}, 32'h0);
    $display("reset-mid: m0_ack=%b m1_ack=%b", bus.m0_ack, bus.m1_ack);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rmid_m1_next_addr", bus.mem_addr, 32'h0000_0024);
    @(negedge clk);
    chk("rmid_m1_ack", {31'h0, bus.m1_ack}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Early drop: req released during BUSY, transaction still completes.
    preload(12'd4, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("drop_m0_ack", {31'h0, bus.m0_ack}, 32'h1);
    chk("drop_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    $display("early-drop: m0_ack=%b rdata=%h", bus.m0_ack, bus.m0_rdata);
    @(negedge clk);
    chk("drop_after_ack", {31'h0, bus.m0_ack}, 32'h0);
    @(negedge clk);
    chk("drop_no_regrant", {31'h0, bus.mem_en}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
